// File: rtl/fpmul_result_collector_if.sv
// Handshake bundle between the fpmul product source, the result collector
// and the downstream consumer. valid/ready rule on both sides: a word moves
// on a rising edge where valid && ready; the sender keeps valid and the
// payload steady until that edge, and ready may depend on state only.
interface fpmul_result_collector_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_overflow;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_flags;

    // Collector side: accepts products, presents normalised results.
    modport slave (
        input  in_valid, in_data, in_overflow, in_sub, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );

    // Environment side: drives products and consumes results.
    modport master (
        output in_valid, in_data, in_overflow, in_sub, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );
endinterface

// File: rtl/fpmul_result_collector.sv
// Result collector behind the FP16 multiplier: normalises special values
// (overflow -> signed inf, optional flush-to-zero, canonical quiet NaN),
// buffers results in a DEPTH-entry FIFO and keeps saturating exception
// counters. The FIFO head is read straight from the storage array, so a
// push is visible at the output one edge later.
module fpmul_result_collector #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8,
    parameter bit FTZ   = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RST,
    fpmul_result_collector_if.slave  bus,
    input  logic                     clr_cnt,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         ovf_cnt,
    output logic [CNT_W-1:0]         sub_cnt,
    output logic [CNT_W-1:0]         nan_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [15:0]   mem_data  [DEPTH];
    logic [2:0]    mem_flags [DEPTH];

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [15:0]   norm_data;
    logic [2:0]    norm_flags;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop never frees space for a same-cycle push: in_ready looks at full only.
    assign push = bus.in_valid && !full;
    assign pop  = bus.out_ready && !empty;

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_data  = mem_data[rd_ptr[AW-1:0]];
    assign bus.out_flags = mem_flags[rd_ptr[AW-1:0]];
    assign fifo_count    = wr_ptr - rd_ptr;

    // Normalise the incoming product; the first matching rule wins.
    always_comb begin
        norm_data  = bus.in_data;
        norm_flags = 3'b000;
        if (bus.in_overflow) begin
            norm_data  = {bus.in_data[15], 5'b11111, 10'b0};
            norm_flags = 3'b100;
        end else if (bus.in_sub) begin
            norm_data  = FTZ ? {bus.in_data[15], 15'b0} : bus.in_data;
            norm_flags = 3'b010;
        end else if (bus.in_data[14:10] == 5'b11111 && bus.in_data[9:0] != 10'b0) begin
            norm_data  = 16'h7E00;
            norm_flags = 3'b001;
        end
    end

    // FIFO pointers; reset drops every buffered entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i]  <= 16'h0000;
                mem_flags[i] <= 3'b000;
            end
        end else if (push) begin
            mem_data[wr_ptr[AW-1:0]]  <= norm_data;
            mem_flags[wr_ptr[AW-1:0]] <= norm_flags;
        end
    end

    // Saturating exception counters; a clear drops any same-cycle increment.
    always_ff @(posedge CLK) begin
        if (RST || clr_cnt) begin
            ovf_cnt <= '0;
            sub_cnt <= '0;
            nan_cnt <= '0;
        end else if (push) begin
            if (norm_flags[2] && ovf_cnt != CNT_MAX) ovf_cnt <= ovf_cnt + 1'b1;
            if (norm_flags[1] && sub_cnt != CNT_MAX) sub_cnt <= sub_cnt + 1'b1;
            if (norm_flags[0] && nan_cnt != CNT_MAX) nan_cnt <= nan_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fpmul_result_collector.sv
// Bench for fpmul_result_collector. Two instances share one stimulus stream:
// dut_a (DEPTH=4, CNT_W=4, FTZ=1) and dut_b (DEPTH=4, CNT_W=8, FTZ=0).
// A queue-based reference model predicts every output before each edge.
module tb_fpmul_result_collector;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    logic        in_valid    = 1'b0;
    logic [15:0] in_data     = 16'h0;
    logic        in_overflow = 1'b0;
    logic        in_sub      = 1'b0;
    logic        out_ready   = 1'b0;
    logic        clr_cnt     = 1'b0;

    logic [2:0] fifo_count_a, fifo_count_b;
    logic [3:0] ovf_a, sub_a, nan_a;
    logic [7:0] ovf_b, sub_b, nan_b;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    fpmul_result_collector_if bus_a ();
    fpmul_result_collector_if bus_b ();

    assign bus_a.in_valid    = in_valid;
    assign bus_a.in_data     = in_data;
    assign bus_a.in_overflow = in_overflow;
    assign bus_a.in_sub      = in_sub;
    assign bus_a.out_ready   = out_ready;
    assign bus_b.in_valid    = in_valid;
    assign bus_b.in_data     = in_data;
    assign bus_b.in_overflow = in_overflow;
    assign bus_b.in_sub      = in_sub;
    assign bus_b.out_ready   = out_ready;

    fpmul_result_collector #(.DEPTH(4), .CNT_W(4), .FTZ(1'b1)) dut_a (
        .CLK(CLK), .RST(RST), .bus(bus_a), .clr_cnt(clr_cnt),
        .fifo_count(fifo_count_a), .ovf_cnt(ovf_a), .sub_cnt(sub_a), .nan_cnt(nan_a)
    );

    fpmul_result_collector #(.DEPTH(4), .CNT_W(8), .FTZ(1'b0)) dut_b (
        .CLK(CLK), .RST(RST), .bus(bus_b), .clr_cnt(clr_cnt),
        .fifo_count(fifo_count_b), .ovf_cnt(ovf_b), .sub_cnt(sub_b), .nan_cnt(nan_b)
    );

    // ---------------- reference model ----------------
    localparam int DEPTH = 4;
    logic [18:0] exp_q_a[$];   // {flags, data}
    logic [18:0] exp_q_b[$];
    int  cnt_a[3];             // ovf, sub, nan
    int  cnt_b[3];
    bit  fresh;                // nothing pushed since reset: head storage still zero

    function automatic logic [18:0] norm(input logic [15:0] d, input logic ovf,
                                         input logic sb, input bit ftz);
        if (ovf)                                        return {3'b100, d[15], 15'h7C00};
        else if (sb)                                    return {3'b010, ftz ? {d[15], 15'h0} : d};
        else if (d[14:10] == 5'h1F && d[9:0] != 10'h0)  return {3'b001, 16'h7E00};
        else                                            return {3'b000, d};
    endfunction

    function automatic int bump(input int c, input int maxv);
        return (c < maxv) ? c + 1 : maxv;
    endfunction

    task automatic model_reset();
        exp_q_a.delete();
        exp_q_b.delete();
        for (int i = 0; i < 3; i++) begin
            cnt_a[i] = 0;
            cnt_b[i] = 0;
        end
        fresh = 1'b1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int sz;
        sz = exp_q_a.size();
        check("in_ready",  32'(bus_a.in_ready),  32'(sz < DEPTH));
        check("in_ready_b", 32'(bus_b.in_ready), 32'(sz < DEPTH));
        check("out_valid", 32'(bus_a.out_valid), 32'(sz > 0));
        check("out_valid_b", 32'(bus_b.out_valid), 32'(sz > 0));
        check("fifo_count", 32'(fifo_count_a), 32'(sz));
        check("fifo_count_b", 32'(fifo_count_b), 32'(sz));
        if (sz > 0) begin
            check("out_data",    32'(bus_a.out_data),  32'(exp_q_a[0][15:0]));
            check("out_flags",   32'(bus_a.out_flags), 32'(exp_q_a[0][18:16]));
            check("out_data_b",  32'(bus_b.out_data),  32'(exp_q_b[0][15:0]));
            check("out_flags_b", 32'(bus_b.out_flags), 32'(exp_q_b[0][18:16]));
        end else if (fresh) begin
            check("idle_data",   32'(bus_a.out_data),  32'h0);
            check("idle_flags",  32'(bus_a.out_flags), 32'h0);
            check("idle_data_b", 32'(bus_b.out_data),  32'h0);
        end
        check("ovf_cnt", 32'(ovf_a), 32'(cnt_a[0]));
        check("sub_cnt", 32'(sub_a), 32'(cnt_a[1]));
        check("nan_cnt", 32'(nan_a), 32'(cnt_a[2]));
        check("ovf_cnt_b", 32'(ovf_b), 32'(cnt_b[0]));
        check("sub_cnt_b", 32'(sub_b), 32'(cnt_b[1]));
        check("nan_cnt_b", 32'(nan_b), 32'(cnt_b[2]));
    endtask

    // ---------------- driver ----------------
    // One clock cycle: drive at negedge, check pre-edge outputs, advance model.
    task automatic step(input logic v, input logic [15:0] d, input logic ovf,
                        input logic sb, input logic ordy, input logic clr,
                        input logic r, output bit accepted);
        bit push, pop;
        logic [18:0] na, nb;
        @(negedge CLK);
        in_valid = v; in_data = d; in_overflow = ovf; in_sub = sb;
        out_ready = ordy; clr_cnt = clr; RST = r;
        #1;
        check_outputs();
        push = v && (exp_q_a.size() < DEPTH);
        pop  = ordy && (exp_q_a.size() > 0);
        accepted = push && !r;
        @(posedge CLK);
        if (r) begin
            model_reset();
        end else begin
            if (pop) begin
                void'(exp_q_a.pop_front());
                void'(exp_q_b.pop_front());
            end
            if (push) begin
                na = norm(d, ovf, sb, 1'b1);
                nb = norm(d, ovf, sb, 1'b0);
                exp_q_a.push_back(na);
                exp_q_b.push_back(nb);
                fresh = 1'b0;
            end
            if (clr) begin
                for (int i = 0; i < 3; i++) begin
                    cnt_a[i] = 0;
                    cnt_b[i] = 0;
                end
            end else if (push) begin
                for (int i = 0; i < 3; i++) begin
                    if (na[18-i]) cnt_a[i] = bump(cnt_a[i], 15);
                    if (nb[18-i]) cnt_b[i] = bump(cnt_b[i], 255);
                end
            end
        end
    endtask

    task automatic idle(input logic ordy);
        bit acc;
        step(1'b0, 16'h0, 1'b0, 1'b0, ordy, 1'b0, 1'b0, acc);
    endtask

    task automatic push_word(input logic [15:0] d, input logic ovf, input logic sb,
                             input logic ordy);
        bit acc;
        step(1'b1, d, ovf, sb, ordy, 1'b0, 1'b0, acc);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q_a.size() > 0 && guard < 20) begin
            idle(1'b1);
            guard++;
        end
        check("drain_timeout", 32'(exp_q_a.size()), 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit acc;
        int guard;
        logic [15:0] rd;
        model_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);

        // Overflow saturates to signed infinity.
        push_word(16'h7BFF, 1'b1, 1'b0, 1'b1);
        push_word(16'hFC00, 1'b1, 1'b0, 1'b1);
        // Subnormal: flushed in dut_a, passed in dut_b.
        push_word(16'h8009, 1'b0, 1'b1, 1'b1);
        // NaNs canonicalised, normal value unchanged.
        push_word(16'h7FFF, 1'b0, 1'b0, 1'b1);
        push_word(16'hFE01, 1'b0, 1'b0, 1'b1);
        push_word(16'h4AA7, 1'b0, 1'b0, 1'b1);
        push_word(16'hFC00, 1'b0, 1'b0, 1'b1);
        drain();

        // Fill with consumer stalled; fifth word held by the source.
        for (int i = 1; i <= 5; i++) push_word(16'(i), 1'b0, 1'b0, 1'b0);
        guard = 0;
        acc = 1'b0;
        while (!acc && guard < 10) begin
            step(1'b1, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
            guard++;
        end
        check("hold_accept", 32'(acc), 32'h1);
        drain();

        // Simultaneous push and pop at occupancy 2.
        push_word(16'h1111, 1'b0, 1'b0, 1'b0);
        push_word(16'h2222, 1'b0, 1'b0, 1'b0);
        push_word(16'h3333, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        drain();

        // Counter saturation in dut_a, then clear racing an overflow push.
        for (int i = 0; i < 20; i++) push_word(16'h3C00, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'h3C00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        idle(1'b1);
        drain();

        // Reset mid-operation with a word offered in the reset cycle.
        push_word(16'h0101, 1'b1, 1'b0, 1'b0);
        push_word(16'h0202, 1'b0, 1'b1, 1'b0);
        push_word(16'h7C01, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0404, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        idle(1'b0);
        idle(1'b1);

        // Randomised traffic with special-value bias.
        for (int i = 0; i < 400; i++) begin
            rd = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rd[14:10] = 5'h1F;
                1: rd[14:10] = 5'h00;
                default: ;
            endcase
            step(1'($urandom_range(0, 3) != 0), rd,
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0),
                 1'($urandom_range(0, 120) == 0), acc);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fpmul_result_collector.md
Name: fpmul_result_collector

Overview:
- Downstream stage of the FP16 multiplier `fpmul`.
- Accepts each product word plus its `overflow` and `sub` flags over a valid/ready handshake.
- Normalises special values:
  - overflow saturates to signed infinity;
  - optional flush-to-zero of subnormals;
  - NaNs become a canonical quiet NaN.
- Buffers results in a small FIFO for the consumer and keeps saturating exception counters for test/debug.

Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- CNT_W, 8: width of each exception counter.
- FTZ, 1: 1 = subnormal results flushed to signed zero; 0 = passed unchanged.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  product word valid.
- in_ready  out  1  collector can accept; equals !full.
- in_data  in  16  FP16 product from `fpmul` `out`.
- in_overflow  in  1  `fpmul` `overflow` flag.
- in_sub  in  1  `fpmul` `sub` (subnormal/underflow) flag.
- out_valid  out  1  FIFO head valid; equals !empty.
- out_ready  in  1  consumer accepts head.
- out_data  out  16  normalised FP16 result at FIFO head.
- out_flags  out  3  {ovf, sub, nan} of head entry.
- fifo_count  out  $clog2(DEPTH)+1  entries held.
- ovf_cnt, sub_cnt, nan_cnt  out  CNT_W each  saturating event counters.
- clr_cnt  in  1  synchronous clear of the three counters.

Behaviour:
- Reset (RST=1 at an edge):
  - rd/wr pointers and fifo_count = 0; out_valid = 0; in_ready = 1.
  - out_data = 16'h0000; out_flags = 0; all counters = 0.
  - Reset mid-operation discards every buffered entry.
- Push / pop:
  - Push occurs when in_valid && in_ready.
  - Pop occurs when out_valid && out_ready.
  - Simultaneous push and pop is legal at any non-full, non-empty occupancy: count unchanged.
  - When full, in_ready = 0; a pop in that cycle does not enable a same-cycle push.
  - When empty, no pop; a push makes out_valid = 1 on the next edge (latency 1 cycle, FIFO head registered).
  - Pointers wrap modulo DEPTH. out_data and out_flags are stable while out_valid && !out_ready.
- Normalisation, combinational on push, first matching rule wins. s = in_data[15], e = in_data[14:10], m = in_data[9:0]:
  1. in_overflow=1 → {s,5'b11111,10'b0}; flags 3'b100.
  2. in_sub=1 → FTZ=1: {s,15'b0}; FTZ=0: in_data unchanged; flags 3'b010 in both cases.
  3. e=5'b11111 && m≠0 → 16'h7E00, sign dropped; flags 3'b001.
  4. Otherwise → in_data unchanged; flags 3'b000 (includes ±inf without overflow flag, ±0).
- Counters:
  - On each push, increment the counter matching the set flag.
  - Each counter saturates at 2^CNT_W−1; no wrap.
  - clr_cnt=1 zeroes all three counters; clear wins over a same-cycle increment, which is dropped.
  - Counters count only accepted pushes, not pops.
- in_overflow and in_sub are sampled only on a push; they are ignored when in_valid=0 or in_ready=0.

Test Plan:
1. Reset, then push in_data=16'h7BFF with in_overflow=1 (out_ready=1) → next cycle out_valid=1, out_data=16'h7C00, out_flags=3'b100, ovf_cnt=1. Push 16'hFC00 with overflow=1 → out_data=16'hFC00.
2. FTZ=1: push 16'h8009 with in_sub=1 → out_data=16'h8000, flags 3'b010, sub_cnt=1. FTZ=0 build, same stimulus → out_data=16'h8009, flags 3'b010.
3. Push 16'h7FFF, then 16'hFE01 (no flags) → out_data=16'h7E00 both times, flags 3'b001, nan_cnt=2. Push 16'h4AA7 → passes unchanged, flags 3'b000.
4. DEPTH=4, out_ready=0: push 16'h0001..16'h0005 on consecutive cycles →
   - in_ready falls after the 4th push; fifo_count=4; the 5th word is held by the source.
   - Then out_ready=1 → drains 0001, 0002, 0003, 0004, 0005 in order; the 5th word is accepted one cycle after the first pop.
   - Simultaneous push and pop at count=2 keeps count=2.
5. CNT_W=4: 20 overflow pushes → ovf_cnt=15. clr_cnt=1 in the same cycle as another overflow push → ovf_cnt=0 next cycle.
6. Three entries buffered, assert RST for one edge with in_valid=1 → fifo_count=0, out_valid=0, out_data=16'h0000, counters 0, no entry from the reset cycle retained.
